// File: rtl/vedic_pkg.sv
// ----------------------------------------------------------------------------
// vedic_pkg
// Shared constants and helpers for the pipelined Vedic multiplier.
//   VEDIC_PIPE_LAT   : register stages between input acceptance and result
//   vedic_width_ok() : legal operand width (even and at least 4)
//   vedic_cross_w()  : width of the S2 cross sum for a given operand width.
//                      With H = WIDTH/2 this is 2H+2 = WIDTH+2, wide enough to
//                      hold hl + lh + (ll >> H) without losing a carry.
// ----------------------------------------------------------------------------
package vedic_pkg;

    localparam int VEDIC_PIPE_LAT = 3;

    function automatic bit vedic_width_ok(input int width);
        return (width >= 4) && ((width % 2) == 0);
    endfunction

    function automatic int vedic_cross_w(input int width);
        return width + 2;
    endfunction

    // Cross-sum type for the default 16-bit build; the top derives its own
    // cross type from vedic_cross_w() so other widths work unchanged.
    typedef logic [vedic_cross_w(16)-1:0] vedic_cross16_t;

endpackage

// File: rtl/vedic_mult_pipe_if.sv
// ----------------------------------------------------------------------------
// vedic_mult_pipe_if
// Operand/result stream bundle for vedic_mult_pipe.
//   in_valid/in_ready/a/b        : operand stream into the multiplier
//   out_valid/out_ready/result   : product stream out of the multiplier
// Handshake: a beat transfers on a rising edge where valid and ready are both
// 1. in_ready depends combinationally on out_ready (single global stall).
//   master : the producer/consumer side (drives operands and out_ready)
//   slave  : the multiplier side
// ----------------------------------------------------------------------------
interface vedic_mult_pipe_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/vedic_half_mult.sv
// ----------------------------------------------------------------------------
// vedic_half_mult
// Combinational unsigned W x W Urdhva-Tiryakbhyam multiplier. Operands are
// split recursively into halves until 2x2 crosswise cells remain.
//   i_a, i_b : W-bit unsigned operands
//   o_p      : 2W-bit unsigned product
// Odd widths split into a narrower low part (L) and wider high part (U); the
// low part is zero-extended so all four sub-products share width U.
// ----------------------------------------------------------------------------
module vedic_half_mult #(
    parameter int W = 8
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);
    generate
        if (W == 1) begin : g_bit
            assign o_p = {1'b0, i_a[0] & i_b[0]};
        end else if (W == 2) begin : g_cell
            // Vertical terms at the ends, crosswise sum in the middle.
            logic [1:0] w_t;
            logic [1:0] w_u;
            assign w_t = {1'b0, i_a[1] & i_b[0]} + {1'b0, i_a[0] & i_b[1]};
            assign w_u = {1'b0, i_a[1] & i_b[1]} + {1'b0, w_t[1]};
            assign o_p = {w_u, w_t[0], i_a[0] & i_b[0]};
        end else begin : g_split
            localparam int L = W / 2;
            localparam int U = W - L;
            logic [U-1:0]   w_al, w_ah, w_bl, w_bh;
            logic [2*U-1:0] w_ll, w_hl, w_lh, w_hh;

            assign w_al = U'(i_a[L-1:0]);
            assign w_bl = U'(i_b[L-1:0]);
            assign w_ah = i_a[W-1:L];
            assign w_bh = i_b[W-1:L];

            vedic_half_mult #(.W(U)) u_ll (.i_a(w_al), .i_b(w_bl), .o_p(w_ll));
            vedic_half_mult #(.W(U)) u_hl (.i_a(w_ah), .i_b(w_bl), .o_p(w_hl));
            vedic_half_mult #(.W(U)) u_lh (.i_a(w_al), .i_b(w_bh), .o_p(w_lh));
            vedic_half_mult #(.W(U)) u_hh (.i_a(w_ah), .i_b(w_bh), .o_p(w_hh));

            assign o_p = (2*W)'(w_ll)
                       + ((2*W)'(w_hl) << L)
                       + ((2*W)'(w_lh) << L)
                       + ((2*W)'(w_hh) << (2*L));
        end
    endgenerate
endmodule

// File: rtl/vedic_mult_pipe.sv
// ----------------------------------------------------------------------------
// vedic_mult_pipe
// Three-stage pipelined Vedic multiplier with a valid/ready stream.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears valid bits and result)
//   s     : vedic_mult_pipe_if.slave (operands in, product out)
// Stages: S1 four H x H partial products, S2 cross sum, S3 final recombine.
// A single global enable freezes every stage while the output is stalled.
// Optional feature: define VEDIC_MULT_SIGNED_EN for two's complement operands
// (magnitudes are multiplied and the product is negated in S3).
// ----------------------------------------------------------------------------
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mult_pipe_if.slave s
);
    localparam int H = WIDTH / 2;
    typedef logic [vedic_cross_w(WIDTH)-1:0] cross_t;

    generate
        if (!vedic_width_ok(WIDTH)) begin : g_bad_width
            $error("vedic_mult_pipe: WIDTH must be even and >= 4");
        end
    endgenerate

    logic w_stall;
    logic w_en;

    assign w_stall    = s.out_valid & ~s.out_ready;
    assign w_en       = ~w_stall;
    assign s.in_ready = w_en;

    // Operand magnitudes feeding the partial-product multipliers.
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

`ifdef VEDIC_MULT_SIGNED_EN
    logic w_sign;
    logic r_s1;
    logic r_s2;
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_a_mag = s.a[WIDTH-1] ? (~s.a + WIDTH'(1)) : s.a;
    assign w_b_mag = s.b[WIDTH-1] ? (~s.b + WIDTH'(1)) : s.b;
    assign w_sign  = s.a[WIDTH-1] ^ s.b[WIDTH-1];
`else
    assign w_a_mag = s.a;
    assign w_b_mag = s.b;
`endif

    logic [2*H-1:0] w_ll, w_hl, w_lh, w_hh;

    vedic_half_mult #(.W(H)) u_ll (.i_a(w_a_mag[H-1:0]),     .i_b(w_b_mag[H-1:0]),     .o_p(w_ll));
    vedic_half_mult #(.W(H)) u_hl (.i_a(w_a_mag[WIDTH-1:H]), .i_b(w_b_mag[H-1:0]),     .o_p(w_hl));
    vedic_half_mult #(.W(H)) u_lh (.i_a(w_a_mag[H-1:0]),     .i_b(w_b_mag[WIDTH-1:H]), .o_p(w_lh));
    vedic_half_mult #(.W(H)) u_hh (.i_a(w_a_mag[WIDTH-1:H]), .i_b(w_b_mag[WIDTH-1:H]), .o_p(w_hh));

    // Stage registers.
    logic               r_v1, r_v2, r_v3;
    logic [2*H-1:0]     r_ll, r_hl, r_lh, r_hh;
    cross_t             r_cross;
    logic [H-1:0]       r_ll_lo;
    logic [2*H-1:0]     r_hh2;
    logic [2*WIDTH-1:0] r_result;

    cross_t             w_cross;
    logic [2*H-1:0]     w_top;
    logic [2*WIDTH-1:0] w_uprod;
    logic [2*WIDTH-1:0] w_final;

    assign w_cross = cross_t'(r_hl) + cross_t'(r_lh) + cross_t'(r_ll[2*H-1:H]);
    assign w_top   = r_hh2 + (2*H)'(r_cross[2*H+1:H]);
    assign w_uprod = {w_top, r_cross[H-1:0], r_ll_lo};

`ifdef VEDIC_MULT_SIGNED_EN
    assign w_final = r_s2 ? (~w_uprod + (2*WIDTH)'(1)) : w_uprod;
`else
    assign w_final = w_uprod;
`endif

    // Control path: valid bits and result are reset; result only loads real
    // products so it keeps its last value across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_result <= '0;
        end else if (w_en) begin
            r_v1 <= s.in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_v2) begin
                r_result <= w_final;
            end
        end
    end

    // Datapath: no reset needed, contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_ll    <= w_ll;
            r_hl    <= w_hl;
            r_lh    <= w_lh;
            r_hh    <= w_hh;
            r_cross <= w_cross;
            r_ll_lo <= r_ll[H-1:0];
            r_hh2   <= r_hh;
`ifdef VEDIC_MULT_SIGNED_EN
            r_s1    <= w_sign;
            r_s2    <= r_s1;
`endif
        end
    end

    assign s.out_valid = r_v3;
    assign s.result    = r_result;
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// ----------------------------------------------------------------------------
// tb_vedic_mult_pipe
// Self-checking bench for vedic_mult_pipe (WIDTH=16). Expected products come
// from plain integer multiplication; a monitor records every output beat and
// each scenario task compares the recorded beats with its expected queue.
// Build with +define+VEDIC_MULT_SIGNED_EN to exercise signed mode.
// ----------------------------------------------------------------------------
module tb_vedic_mult_pipe;
    import vedic_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] obs_q[$];

    vedic_mult_pipe_if #(.WIDTH(W)) vif ();

    vedic_mult_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (vif.slave)
    );

    always #5 clk = ~clk;

    // Output monitor: a beat transfers on the edge following this sample.
    always @(negedge clk) begin
        if (rst_n && vif.out_valid && vif.out_ready) begin
            obs_q.push_back(vif.result);
        end
    end

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
`ifdef VEDIC_MULT_SIGNED_EN
        p = longint'($signed(x)) * longint'($signed(y));
`else
        p = longint'(x) * longint'(y);
`endif
        return p[2*W-1:0];
    endfunction

    // Present one operand pair and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output int waited);
        vif.in_valid = 1'b1;
        vif.a = x;
        vif.b = y;
        waited = 0;
        @(negedge clk);
        while (!vif.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (!vif.in_ready) begin
            errors++;
            $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", vif.in_ready, waited);
        end else begin
            exp_q.push_back(ref_mul(x, y));
        end
        @(posedge clk);
        #1;
    endtask

    // Stop issuing and wait (bounded) until every expected beat has come out,
    // plus a few extra cycles so duplicates would show up.
    task automatic drain();
        int n;
        n = 0;
        vif.in_valid = 1'b0;
        while (obs_q.size() < exp_q.size() && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vif.in_valid  = 1'b0;
        vif.a         = '0;
        vif.b         = '0;
        vif.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", vif.out_valid); end
        checks++;
        if (vif.result !== '0) begin errors++; $display("FAIL reset_result: got %h, required 0", vif.result); end
        checks++;
        if (vif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", vif.in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (vif.in_ready !== 1'b1 || vif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: in_ready=%0b out_valid=%0b, required 1/0", vif.in_ready, vif.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    // 0xFFFF * 0xFFFF: check latency edge by edge and the final value.
    task automatic test_latency_max();
        logic [2*W-1:0] want;
`ifdef VEDIC_MULT_SIGNED_EN
        want = 32'h0000_0001;
`else
        want = 32'hFFFE_0001;
`endif
        vif.out_ready = 1'b1;
        vif.in_valid  = 1'b1;
        vif.a         = 16'hFFFF;
        vif.b         = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (vif.in_ready !== 1'b1) begin errors++; $display("FAIL max_accept: in_ready=%0b, required 1", vif.in_ready); end
        @(posedge clk);
        #1;
        vif.in_valid = 1'b0;
        for (int k = 1; k <= VEDIC_PIPE_LAT; k++) begin
            @(negedge clk);
            checks++;
            if (vif.out_valid !== (k == VEDIC_PIPE_LAT)) begin
                errors++;
                $display("FAIL latency_edge%0d: out_valid=%0b, required %0b", k, vif.out_valid, (k == VEDIC_PIPE_LAT));
            end
            if (k < VEDIC_PIPE_LAT) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (vif.result !== want) begin errors++; $display("FAIL max_result: got %h, required %h", vif.result, want); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL max_single_beat: out_valid=%0b, required 0", vif.out_valid); end
        @(posedge clk);
        #1;
        obs_q.delete();
        exp_q.delete();
    endtask

    // Boundary operands with hand-computed products.
    task automatic test_corners();
        logic [W-1:0]   ta[4];
        logic [W-1:0]   tb[4];
        logic [2*W-1:0] tw[4];
        int waited;
        ta = '{16'h0000, 16'h0001, 16'h8000, 16'h7FFF};
        tb = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
`ifdef VEDIC_MULT_SIGNED_EN
        tw = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 32'hC000_8000};
`else
        tw = '{32'h0000_0000, 32'h0000_FFFF, 32'h4000_0000, 32'h3FFF_8000};
`endif
        vif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(ta[i], tb[i], waited);
        drain();
        checks++;
        if (obs_q.size() !== 4) begin errors++; $display("FAIL corner_count: got %0d, required 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== tw[i]) begin
                errors++;
                $display("FAIL corner_%0d: %h*%h got %h, required %h", i, ta[i], tb[i], obs_q[i], tw[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int waited;
        int stalls;
        stalls = 0;
        vif.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(W'($urandom), W'($urandom), waited);
            if (waited != 0) stalls++;
        end
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL stream_in_ready: %0d stalled beats, required 0", stalls); end
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL stream_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int waited;
        logic [W-1:0] x3, y3;
        vif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), waited);
        x3 = W'($urandom);
        y3 = W'($urandom);
        vif.in_valid = 1'b1;
        vif.a = x3;
        vif.b = y3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (vif.in_ready !== 1'b0 || vif.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall%0d: in_ready=%0b out_valid=%0b, required 0/1", c, vif.in_ready, vif.out_valid);
            end
            checks++;
            if (vif.result !== exp_q[0]) begin errors++; $display("FAIL bp_hold%0d: got %h, required %h", c, vif.result, exp_q[0]); end
            @(posedge clk);
            #1;
        end
        vif.out_ready = 1'b1;
        send(x3, y3, waited);
        drain();
        checks++;
        if (obs_q.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d, required 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Random in_valid and out_ready; operands are held until accepted.
    task automatic test_random_flow();
        logic [W-1:0] x, y;
        vif.in_valid  = 1'b0;
        vif.out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!vif.in_valid || vif.in_ready) begin
                x = W'($urandom);
                y = W'($urandom);
                vif.a = x;
                vif.b = y;
                vif.in_valid = ($urandom_range(0, 3) != 0);
            end
            vif.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (vif.in_valid && vif.in_ready) exp_q.push_back(ref_mul(x, y));
            @(posedge clk);
            #1;
        end
        vif.out_ready = 1'b1;
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL flow_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL flow_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Two products in flight when reset hits: neither may ever appear.
    task automatic test_reset_mid_flight();
        int waited;
        vif.out_ready = 1'b1;
        send(16'h1234, 16'h5678, waited);
        send(16'h9ABC, 16'hDEF0, waited);
        vif.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %0b, required 0", vif.out_valid); end
        checks++;
        if (vif.result !== '0) begin errors++; $display("FAIL mid_reset_result: got %h, required 0", vif.result); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_ghost%0d: out_valid=%0b, required 0", c, vif.out_valid); end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL mid_reset_beats: got %0d, required 0", obs_q.size()); end
        @(posedge clk);
        #1;
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_latency_max();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_random_flow();
        test_reset_mid_flight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
